// File: rtl/sprite_line_evaluator.sv
// Purpose: per-scanline OAM scan that selects sprites covering the requested line and emits render descriptors.
// Latency: start -> first OAM eval after 2 cycles; 2 cycles per entry plus cycles held in EMIT per accepted hit.
// Backpressure: descriptor held stable on o_valid until i_ready; the scan pauses while the renderer stalls.
module sprite_line_evaluator #(
    parameter int NUM_SPRITES   = 64,
    parameter int MAX_PER_LINE  = 16,
    parameter int SPRITE_HEIGHT = 32
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_line_start,
    input  logic [9:0]                        i_line_y,
    output logic [$clog2(NUM_SPRITES)-1:0]    o_oam_addr,
    input  logic [47:0]                       i_oam_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [15:0]                       o_sprite_line_address,
    output logic [9:0]                        o_sprite_start_x,
    output logic                              o_tile_row,
    output logic                              o_row_flip,
    output logic [$clog2(MAX_PER_LINE):0]     o_count,
    output logic                              o_overflow,
    output logic                              o_done
);

    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int CNT_W = $clog2(MAX_PER_LINE) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_LINE);
    localparam logic [9:0]       HEIGHT   = 10'(SPRITE_HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EVAL  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] index;
    logic [9:0]       line_y;

    // OAM word fields
    logic [9:0]  spr_y;
    logic [9:0]  spr_x;
    logic [15:0] spr_base;
    logic        spr_vflip;
    logic        spr_en;
    logic        unused_oam;

    assign spr_y      = i_oam_data[9:0];
    assign spr_x      = i_oam_data[19:10];
    assign spr_base   = i_oam_data[35:20];
    assign spr_vflip  = i_oam_data[36];
    assign spr_en     = i_oam_data[37];
    assign unused_oam = ^i_oam_data[47:38];

    // The RAM address simply follows the scan index; data arrives in EVAL.
    assign o_oam_addr = index;

    // Row within the sprite; 10-bit subtraction gives the wrap across line 1023 -> 0.
    logic [9:0]  row;
    logic [9:0]  eff_row;
    logic        hit;
    logic [15:0] line_addr;

    // Hit test and flipped-row address for the entry currently on i_oam_data.
    always_comb begin
        row       = line_y - spr_y;
        hit       = spr_en && (row < HEIGHT);
        eff_row   = spr_vflip ? (HEIGHT - 10'd1 - row) : row;
        line_addr = spr_base + {6'd0, eff_row};
    end

    // Scan FSM: fetch/eval per entry, emit hits over valid/ready, pulse done at the end.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state                 <= S_IDLE;
            index                 <= '0;
            line_y                <= '0;
            o_valid               <= 1'b0;
            o_sprite_line_address <= '0;
            o_sprite_start_x      <= '0;
            o_tile_row            <= 1'b0;
            o_row_flip            <= 1'b0;
            o_count               <= '0;
            o_overflow            <= 1'b0;
            o_done                <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_line_start) begin
                // A start in any state restarts the scan; a coincident handshake is dropped.
                line_y     <= i_line_y;
                index      <= '0;
                o_count    <= '0;
                o_overflow <= 1'b0;
                o_valid    <= 1'b0;
                state      <= S_FETCH;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_FETCH: begin
                        state <= S_EVAL;
                    end
                    S_EVAL: begin
                        if (hit && (o_count != MAX_CNT)) begin
                            o_sprite_line_address <= line_addr;
                            o_sprite_start_x      <= spr_x;
                            o_tile_row            <= eff_row[4];
                            o_row_flip            <= spr_vflip;
                            o_valid               <= 1'b1;
                            state                 <= S_EMIT;
                        end else begin
                            // A hit beyond the per-line cap is only recorded as overflow.
                            if (hit) begin
                                o_overflow <= 1'b1;
                            end
                            if (index == LAST_IDX) begin
                                o_done <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                index <= index + 1'b1;
                                state <= S_FETCH;
                            end
                        end
                    end
                    S_EMIT: begin
                        if (i_ready) begin
                            o_valid <= 1'b0;
                            o_count <= o_count + 1'b1;
                            if (index == LAST_IDX) begin
                                o_done <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                index <= index + 1'b1;
                                state <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
